h80cpu_uart_rx: RTL

UART receiver peripheral for the h80 I/O bus, the receive-side counterpart of the I/O bus UART transmitter. It deserialises 8N1 frames from an asynchronous `uart_rxp` line, buffers bytes in a small FIFO, and exposes data and status registers as a bus responder. It uses the same toggle run/done handshake as `h80cpu_mem`. The enclosing I/O module supplies this block's private `run` toggle and routes `rd_data`/`done` back to the CPU.

---
 rtl/h80cpu_uart_rx_pkg.sv | 33 +++
 rtl/h80cpu_fifo.sv | 53 +++++
 rtl/h80cpu_uart_rx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/h80cpu_uart_rx_pkg.sv
// Shared h80 I/O bus types plus UART receiver register map and state encoding.
package h80cpu_uart_rx_pkg;

    typedef logic [15:0] bus_addr_t;
    typedef logic [15:0] bus_data_t;
    typedef logic [2:0]  bus_cmd_t;

    localparam bus_cmd_t bus_cmd_read_w  = 3'd0;
    localparam bus_cmd_t bus_cmd_write_w = 3'd1;
    localparam bus_cmd_t bus_cmd_read_b  = 3'd2;
    localparam bus_cmd_t bus_cmd_write_b = 3'd3;

    localparam bus_addr_t uart_rx_reg_data = 16'h0000;
    localparam bus_addr_t uart_rx_reg_stat = 16'h0002;

    localparam int unsigned uart_rx_stat_valid   = 0;
    localparam int unsigned uart_rx_stat_full    = 1;
    localparam int unsigned uart_rx_stat_overrun = 2;
    localparam int unsigned uart_rx_stat_ferr    = 3;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop,
        RxBreak
    } rx_state_t;

    function automatic logic cmd_is_write(input bus_cmd_t c);
        return (c == bus_cmd_write_w) || (c == bus_cmd_write_b);
    endfunction

endpackage

// File: rtl/h80cpu_fifo.sv
// Synchronous show-ahead FIFO; pushes when full and pops when empty are ignored.
module h80cpu_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == DEPTH[AW:0]);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rptr];
    assign count     = r_count;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/h80cpu_uart_rx.sv
// h80 I/O bus UART receiver: 8N1 deserialiser, receive FIFO and toggle-handshake responder.
module h80cpu_uart_rx
    import h80cpu_uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 27000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic      clk,
    input  logic      reset_,
    input  bus_addr_t addr,
    input  bus_cmd_t  cmd,
    input  logic      run,
    input  bus_data_t wr_data,
    output bus_data_t rd_data,
    output logic      done,
    input  logic      uart_rxp,
    output logic      rx_irq
);

    localparam int unsigned DIV = CLK_FREQ / BAUD;
    localparam int unsigned CW  = $clog2(DIV + 1);
    localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

    logic            r_sync1, r_sync2, r_prev;
    rx_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_overrun, r_ferr, r_done, r_irq;
    bus_data_t       r_rd_data;

    logic            w_tick, w_stop_smp;
    logic            w_push_ev, w_ovr_ev, w_ferr_ev;
    logic            w_req, w_is_wr, w_sel_stat, w_pop;
    logic            w_clr_ovr, w_clr_ferr;
    logic            w_empty, w_full;
    logic [7:0]      w_dout;
    logic [FCW-1:0]  w_count;
    bus_data_t       w_status;
    logic            w_unused;

    assign rd_data = r_rd_data;
    assign done    = r_done;
    assign rx_irq  = r_irq;

    assign w_unused = ^{addr[15:2], addr[0], wr_data[15:4], wr_data[1:0]};

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= uart_rxp;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // r_cnt reaching zero marks the bit-centre sample point.
    assign w_tick     = (r_cnt == '0);
    assign w_stop_smp = (r_state == RxStop) && w_tick;
    assign w_push_ev  = w_stop_smp && r_sync2 && !w_full;
    assign w_ovr_ev   = w_stop_smp && r_sync2 && w_full;
    assign w_ferr_ev  = w_stop_smp && !r_sync2;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= RxIdle;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            if (!w_tick) r_cnt <= r_cnt - 1'b1;
            unique case (r_state)
                RxIdle: begin
                    if (r_prev && !r_sync2) begin
                        r_cnt   <= HALF_LOAD;
                        r_state <= RxStart;
                    end
                end
                RxStart: begin
                    if (w_tick) begin
                        if (!r_sync2) begin
                            r_cnt   <= FULL_LOAD;
                            r_bit   <= '0;
                            r_state <= RxData;
                        end else begin
                            r_state <= RxIdle;
                        end
                    end
                end
                RxData: begin
                    if (w_tick) begin
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_cnt   <= FULL_LOAD;
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) r_state <= RxStop;
                    end
                end
                RxStop: begin
                    if (w_tick) r_state <= r_sync2 ? RxIdle : RxBreak;
                end
                RxBreak: begin
                    if (r_sync2) r_state <= RxIdle;
                end
                default: r_state <= RxIdle;
            endcase
        end
    end

    h80cpu_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_ (reset_),
        .push   (w_push_ev),
        .pop    (w_pop),
        .din    (r_shift),
        .dout   (w_dout),
        .count  (w_count),
        .empty  (w_empty),
        .full   (w_full)
    );

    assign w_req      = (run != r_done);
    assign w_is_wr    = cmd_is_write(cmd);
    assign w_sel_stat = addr[1];
    assign w_pop      = w_req && !w_is_wr && !w_sel_stat && !w_empty;
    assign w_clr_ovr  = w_req && w_is_wr && w_sel_stat && wr_data[uart_rx_stat_overrun];
    assign w_clr_ferr = w_req && w_is_wr && w_sel_stat && wr_data[uart_rx_stat_ferr];

    always_comb begin
        w_status                       = '0;
        w_status[uart_rx_stat_valid]   = !w_empty;
        w_status[uart_rx_stat_full]    = w_full;
        w_status[uart_rx_stat_overrun] = r_overrun;
        w_status[uart_rx_stat_ferr]    = r_ferr;
        w_status[12:8]                 = 5'(w_count);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_done    <= 1'b0;
            r_rd_data <= '0;
            r_overrun <= 1'b0;
            r_ferr    <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_req) begin
                r_done <= ~r_done;
                if (!w_is_wr) begin
                    r_rd_data <= w_sel_stat ? w_status : (w_empty ? '0 : {8'h00, w_dout});
                end
            end
            // A flag event in the same cycle as its W1C clear keeps the flag set.
            r_overrun <= (r_overrun && !w_clr_ovr) || w_ovr_ev;
            r_ferr    <= (r_ferr && !w_clr_ferr) || w_ferr_ev;
            r_irq     <= w_push_ev || (!w_empty && !(w_pop && (w_count == FCW'(1))));
        end
    end

endmodule
